tx_link_ctrl_fsm: RTL

//  JESD204B transmitter link-layer sequencer, directly downstream of the SYNC~ decoder.

---
 rtl/tx_link_ctrl_if.sv | 32 +++
 rtl/tx_link_ctrl_fsm.sv | 114 +++++++++++
 2 files changed

// File: rtl/tx_link_ctrl_if.sv
// Framer-side bundle of the JESD204B TX link sequencer: decoder flags in, framer controls out.
interface tx_link_ctrl_if #(
  parameter int ERR_CNT_W = 8
);
  logic                 frame_clk;
  logic [4:0]           i_K;
  logic                 i_sync_request_tx;
  logic                 i_err_reporting;
  logic                 i_sync_de_assertion;
  logic [1:0]           o_state;
  logic                 o_send_k;
  logic                 o_ilas_start_mf;
  logic                 o_ilas_end_mf;
  logic                 o_ilas_cfg;
  logic [2:0]           o_ilas_mf_idx;
  logic                 o_send_data;
  logic [4:0]           o_frame_pos;
  logic [4:0]           o_deassert_pos;
  logic [ERR_CNT_W-1:0] o_err_cnt;

  modport master (
    output frame_clk, i_K, i_sync_request_tx, i_err_reporting, i_sync_de_assertion,
    input  o_state, o_send_k, o_ilas_start_mf, o_ilas_end_mf, o_ilas_cfg,
           o_ilas_mf_idx, o_send_data, o_frame_pos, o_deassert_pos, o_err_cnt
  );

  modport slave (
    input  frame_clk, i_K, i_sync_request_tx, i_err_reporting, i_sync_de_assertion,
    output o_state, o_send_k, o_ilas_start_mf, o_ilas_end_mf, o_ilas_cfg,
           o_ilas_mf_idx, o_send_data, o_frame_pos, o_deassert_pos, o_err_cnt
  );
endinterface

// File: rtl/tx_link_ctrl_fsm.sv
// JESD204B TX link-layer sequencer: LMFC counter, CGS -> ILAS_WAIT -> ILAS -> DATA,
// ILAS marker decode and saturating error-report counter.
module tx_link_ctrl_fsm #(
  parameter int ILAS_MF   = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  tx_link_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_CGS       = 2'd0,
    S_ILAS_WAIT = 2'd1,
    S_ILAS      = 2'd2,
    S_DATA      = 2'd3
  } state_t;

  localparam logic [2:0] ILAS_LAST = 3'(ILAS_MF - 1);

  state_t               state_q, state_d;
  logic [4:0]           frame_pos_q;
  logic [2:0]           idx_q, idx_d;
  logic [4:0]           deassert_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic                 de_q, err_q, req_seen_q;
  logic                 capture_pos;

  logic lmfc_wrap, lmfc_end, de_rise, err_rise, err_fall, count_err;

  assign lmfc_wrap = (frame_pos_q >= bus.i_K);
  assign lmfc_end  = bus.frame_clk & lmfc_wrap;
  assign de_rise   = bus.i_sync_de_assertion & ~de_q;
  assign err_rise  = bus.i_err_reporting & ~err_q;
  assign err_fall  = ~bus.i_err_reporting & err_q;

  // A fall only counts as a report if no re-init request arrived since the matching rise.
  assign count_err = err_fall & ~req_seen_q & ~bus.i_sync_request_tx &
                     ((state_q == S_ILAS) || (state_q == S_DATA));

  // NOTE: every variable gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    capture_pos = 1'b0;
    if (bus.i_sync_request_tx) begin
      state_d = S_CGS;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        S_CGS: if (de_rise) begin
          state_d     = S_ILAS_WAIT;
          capture_pos = 1'b1;
        end
        S_ILAS_WAIT: if (lmfc_end) begin
          state_d = S_ILAS;
          idx_d   = '0;
        end
        S_ILAS: if (lmfc_end) begin
          if (idx_q == ILAS_LAST) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
        S_DATA: ;
        default: state_d = S_CGS;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_CGS;
      frame_pos_q <= '0;
      idx_q       <= '0;
      deassert_q  <= '0;
      err_cnt_q   <= '0;
      de_q        <= 1'b0;
      err_q       <= 1'b0;
      req_seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      de_q    <= bus.i_sync_de_assertion;
      err_q   <= bus.i_err_reporting;
      if (bus.frame_clk)
        frame_pos_q <= lmfc_wrap ? 5'd0 : frame_pos_q + 5'd1;
      if (capture_pos)
        deassert_q <= frame_pos_q;
      if (count_err && !(&err_cnt_q))
        err_cnt_q <= err_cnt_q + 1'b1;
      if (err_rise)
        req_seen_q <= bus.i_sync_request_tx;
      else if (bus.i_sync_request_tx)
        req_seen_q <= 1'b1;
    end
  end

  assign bus.o_state         = state_q;
  assign bus.o_send_k        = (state_q == S_CGS) || (state_q == S_ILAS_WAIT);
  assign bus.o_send_data     = (state_q == S_DATA);
  assign bus.o_ilas_start_mf = (state_q == S_ILAS) && (frame_pos_q == 5'd0);
  assign bus.o_ilas_end_mf   = (state_q == S_ILAS) && (frame_pos_q == bus.i_K);
  assign bus.o_ilas_cfg      = (ILAS_MF > 1) && (state_q == S_ILAS) &&
                               (idx_q == 3'd1) && (frame_pos_q == 5'd0);
  assign bus.o_ilas_mf_idx   = idx_q;
  assign bus.o_frame_pos     = frame_pos_q;
  assign bus.o_deassert_pos  = deassert_q;
  assign bus.o_err_cnt       = err_cnt_q;

endmodule
